// File: rtl/dout_display_driver_pkg.sv
// Shared types and constants for the CPU output-port display driver:
// FSM encodings, seven-segment glyphs (active-low gfedcba) and BCD helpers.
package dout_display_driver_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   localparam logic [2:0] CONV_LAST = 3'd7;

   function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
      return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
   endfunction

endpackage

// File: rtl/dout_display_driver_seg7_decode.sv
// Combinational digit-to-segment decoder; a blank request or a non-decimal
// digit yields all segments off.
module seg7_decode
   import dout_display_driver_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         seg_o = seg_glyph(digit_i);
      end
   end

endmodule

// File: rtl/dout_display_driver.sv
// Samples CPU Dout/Dval, converts the byte to decimal by double-dabble and
// scans it onto a 4-digit common-anode display. SIGNED_DISPLAY_EN selects a
// two's-complement view with a minus sign on digit 3.
//
// state   | meaning
// IDLE    | compare Dout against shadow byte, capture on change
// CONVERT | one shift-add-3 iteration per clock, 8 in total
module dout_display_driver
   import dout_display_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Dout,
   input  logic       Dval,
   output logic [6:0] Seg,
   output logic [3:0] An,
   output logic       Busy
);

   localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   state_t            state_q, state_d;
   logic [7:0]        shadow_q, shadow_d;
   logic              shadow_vld_q, shadow_vld_d;
   logic [7:0]        work_q, work_d;
   logic [11:0]       bcd_q, bcd_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        disp_h_q, disp_h_d;
   logic [3:0]        disp_t_q, disp_t_d;
   logic [3:0]        disp_u_q, disp_u_d;
   logic              disp_vld_q, disp_vld_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        dig_idx_q, dig_idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        an_q, an_d;

`ifdef SIGNED_DISPLAY_EN
   logic              conv_neg_q, conv_neg_d;
   logic              disp_neg_q, disp_neg_d;
`endif

   logic              capture_req;
   logic [7:0]        magnitude;
   logic [11:0]       bcd_adj;
   logic [11:0]       bcd_next;
   logic [3:0]        sel_digit;
   logic              sel_blank;
   logic              sel_minus;
   logic [6:0]        dec_seg;

   assign capture_req = Dval && (!shadow_vld_q || (Dout != shadow_q));

   // Negation happens at capture so the conversion path is the same in both builds.
   always_comb begin
`ifdef SIGNED_DISPLAY_EN
      magnitude = Dout[7] ? 8'(8'd0 - Dout) : Dout;
`else
      magnitude = Dout;
`endif
   end

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      work_d       = work_q;
      bcd_d        = bcd_q;
      bit_cnt_d    = bit_cnt_q;
      disp_h_d     = disp_h_q;
      disp_t_d     = disp_t_q;
      disp_u_d     = disp_u_q;
      disp_vld_d   = disp_vld_q;
`ifdef SIGNED_DISPLAY_EN
      conv_neg_d   = conv_neg_q;
      disp_neg_d   = disp_neg_q;
`endif
      bcd_adj  = {bcd_adjust(bcd_q[11:8]), bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
      bcd_next = (bcd_adj << 1) | {11'd0, work_q[7]};

      case (state_q)
         IDLE: begin
            if (capture_req) begin
               shadow_d     = Dout;
               shadow_vld_d = 1'b1;
               work_d       = magnitude;
               bcd_d        = 12'd0;
               bit_cnt_d    = 3'd0;
               state_d      = CONVERT;
`ifdef SIGNED_DISPLAY_EN
               conv_neg_d   = Dout[7];
`endif
            end
         end
         CONVERT: begin
            bcd_d     = bcd_next;
            work_d    = work_q << 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == CONV_LAST) begin
               disp_h_d   = bcd_next[11:8];
               disp_t_d   = bcd_next[7:4];
               disp_u_d   = bcd_next[3:0];
               disp_vld_d = 1'b1;
               state_d    = IDLE;
`ifdef SIGNED_DISPLAY_EN
               disp_neg_d = conv_neg_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Seg and An are computed from the next digit index so both flop together.
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      dig_idx_d  = dig_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_idx_d  = dig_idx_q + 2'd1;
      end
      an_d      = ~(4'b0001 << dig_idx_d);
      sel_digit = 4'd0;
      sel_blank = 1'b1;
      sel_minus = 1'b0;
      case (dig_idx_d)
         2'd0: begin
            sel_digit = disp_u_q;
            sel_blank = !disp_vld_q;
         end
         2'd1: begin
            sel_digit = disp_t_q;
            sel_blank = !disp_vld_q || ((disp_h_q == 4'd0) && (disp_t_q == 4'd0));
         end
         2'd2: begin
            sel_digit = disp_h_q;
            sel_blank = !disp_vld_q || (disp_h_q == 4'd0);
         end
         2'd3: begin
`ifdef SIGNED_DISPLAY_EN
            sel_minus = disp_vld_q && disp_neg_q;
`endif
         end
      endcase
      seg_d = sel_minus ? SEG_MINUS : dec_seg;
   end

   seg7_decode u_seg7_decode (
      .digit_i (sel_digit),
      .blank_i (sel_blank),
      .seg_o   (dec_seg)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         shadow_q     <= 8'd0;
         shadow_vld_q <= 1'b0;
         work_q       <= 8'd0;
         bcd_q        <= 12'd0;
         bit_cnt_q    <= 3'd0;
         disp_h_q     <= 4'd0;
         disp_t_q     <= 4'd0;
         disp_u_q     <= 4'd0;
         disp_vld_q   <= 1'b0;
         scan_cnt_q   <= '0;
         dig_idx_q    <= 2'd0;
         seg_q        <= SEG_BLANK;
         an_q         <= 4'hF;
`ifdef SIGNED_DISPLAY_EN
         conv_neg_q   <= 1'b0;
         disp_neg_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         work_q       <= work_d;
         bcd_q        <= bcd_d;
         bit_cnt_q    <= bit_cnt_d;
         disp_h_q     <= disp_h_d;
         disp_t_q     <= disp_t_d;
         disp_u_q     <= disp_u_d;
         disp_vld_q   <= disp_vld_d;
         scan_cnt_q   <= scan_cnt_d;
         dig_idx_q    <= dig_idx_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
`ifdef SIGNED_DISPLAY_EN
         conv_neg_q   <= conv_neg_d;
         disp_neg_q   <= disp_neg_d;
`endif
      end
   end

   assign Seg  = seg_q;
   assign An   = an_q;
   assign Busy = (state_q == CONVERT);

endmodule

// File: tb/tb_dout_display_driver.sv
// Directed bench for dout_display_driver with SCAN_DIV=4; digit-3 expectations
// follow SIGNED_DISPLAY_EN when it is defined.
module tb_dout_display_driver;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] Dout;
   logic       Dval;
   logic [6:0] Seg;
   logic [3:0] An;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   dout_display_driver #(.SCAN_DIV(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Dout  (Dout),
      .Dval  (Dval),
      .Seg   (Seg),
      .An    (An),
      .Busy  (Busy)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare Seg against the glyph expected for whichever digit An selects.
   task automatic chk_now(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                          input logic [6:0] d3, input string tag);
      logic [6:0] exp;
      case (An)
         4'hE:    exp = u;
         4'hD:    exp = t;
         4'hB:    exp = h;
         4'h7:    exp = d3;
         default: exp = 7'bx;
      endcase
      chk({25'd0, Seg}, {25'd0, exp}, $sformatf("%s An=%h", tag, An));
   endtask

   task automatic chk_digits(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                             input logic [6:0] d3, input string tag);
      step();
      for (int i = 0; i < 16; i++) begin
         chk_now(u, t, h, d3, tag);
         step();
      end
   endtask

   // Wait for Busy to rise, then measure its length; optionally change Dout mid-pulse.
   task automatic run_pulse(input int change_at, input logic [7:0] new_dout,
                            output int wait_n, output int len);
      wait_n = 0;
      len    = 0;
      while (!Busy && wait_n < 10) begin
         step();
         wait_n++;
      end
      while (Busy && len < 20) begin
         len++;
         if (len == change_at) Dout = new_dout;
         step();
      end
   endtask

   task automatic conv(input logic [7:0] value, input string tag);
      int w, l;
      Dout = value;
      run_pulse(-1, 8'd0, w, l);
      chk(w, 1, {tag, " capture latency"});
      chk(l, 8, {tag, " busy length"});
   endtask

   initial begin
      int w, l;
      Reset = 1'b1;
      Dval  = 1'b0;
      Dout  = 8'd0;
      step();
      step();
      chk({Seg, An, Busy}, {7'h7F, 4'hF, 1'b0}, "reset outputs");
      Reset = 1'b0;

      for (int k = 1; k <= 100; k++) begin
         step();
         chk({Seg, An, Busy}, {7'h7F, ~(4'b0001 << ((k / 4) % 4)), 1'b0}, "idle scan");
      end

      Dval = 1'b1;
      conv(8'd0, "zero");
      chk_digits(7'h40, 7'h7F, 7'h7F, 7'h7F, "disp 0");

      conv(8'd255, "255");
      chk_digits(7'h12, 7'h12, 7'h24, 7'h7F, "disp 255");

      conv(8'd100, "100");
      chk_digits(7'h40, 7'h40, 7'h79, 7'h7F, "disp 100");

      Dout = 8'd7;
      run_pulse(3, 8'd42, w, l);
      chk(w, 1, "7 capture latency");
      chk(l, 8, "7 busy length");
      step();
      chk(Busy, 1, "42 restart after busy falls");
      for (int i = 0; i < 8; i++) begin
         chk_now(7'h78, 7'h7F, 7'h7F, 7'h7F, "disp 7 during 42");
         step();
      end
      chk(Busy, 0, "42 busy end");
      chk_digits(7'h24, 7'h19, 7'h7F, 7'h7F, "disp 42");

      Dout = 8'd123;
      step();
      chk(Busy, 1, "123 capture");
      step();
      step();
      step();
      chk(Busy, 1, "123 convert cycle 4");
      Reset = 1'b1;
      step();
      chk({Seg, An, Busy}, {7'h7F, 4'hF, 1'b0}, "mid-convert reset");
      Reset = 1'b0;
      run_pulse(-1, 8'd0, w, l);
      chk(w, 1, "123 recapture latency");
      chk(l, 8, "123 busy length");
      chk_digits(7'h30, 7'h24, 7'h79, 7'h7F, "disp 123");

      Dval = 1'b0;
      Dout = 8'd99;
      for (int i = 0; i < 12; i++) begin
         step();
         chk(Busy, 0, "dval low hold");
      end
      chk_digits(7'h30, 7'h24, 7'h79, 7'h7F, "disp 123 held");

      Dval = 1'b1;
`ifdef SIGNED_DISPLAY_EN
      conv(8'hF6, "F6");
      chk_digits(7'h40, 7'h79, 7'h7F, 7'h3F, "disp -10");
      conv(8'h80, "80");
      chk_digits(7'h00, 7'h24, 7'h79, 7'h3F, "disp -128");
`else
      conv(8'hF6, "F6");
      chk_digits(7'h02, 7'h19, 7'h24, 7'h7F, "disp 246");
      conv(8'h80, "80");
      chk_digits(7'h00, 7'h24, 7'h79, 7'h7F, "disp 128");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
